// File: rtl/tri_fetch_scheduler.sv
// tri_fetch_scheduler: walks the face SRAM, fetches each face's three vertices and buffers triangle bundles
// Ports:
//   clk, srst_n (async active-low), enable (frame start), num_of_faces (face count for the frame)
//   address_sram_get_face -> face_v1/2/3 : face SRAM read, data one cycle after the address
//   address_sram_get_vertice_info -> vertice_x/y/z, Color_v : vertex SRAM read, same latency
//   write_enable_*/write_wordmask_* : constant read-mode controls
//   tri_valid/tri_ready/tri_data/tri_last : 2-entry FIFO head towards the vertex shader
//   pipe_idle : downstream empty; finish : frame complete (level)
module tri_fetch_scheduler #(
    parameter int FACE_AW    = 20,
    parameter int VERT_AW    = 20,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               srst_n,
    input  logic               enable,
    input  logic [20:0]        num_of_faces,
    output logic [FACE_AW-1:0] address_sram_get_face,
    input  logic [19:0]        face_v1,
    input  logic [19:0]        face_v2,
    input  logic [19:0]        face_v3,
    output logic [VERT_AW-1:0] address_sram_get_vertice_info,
    input  logic [23:0]        vertice_x,
    input  logic [23:0]        vertice_y,
    input  logic [23:0]        vertice_z,
    input  logic [23:0]        Color_v,
    output logic               write_enable_sram_get_vertice_info,
    output logic [15:0]        write_wordmask_sram_get_vertice_info,
    output logic [15:0]        write_wordmask_sram_get_face,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic [287:0]       tri_data,
    output logic               tri_last,
    input  logic               pipe_idle,
    output logic               finish
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] F_ADDR    = 4'd1;
    localparam logic [3:0] F_DATA    = 4'd2;
    localparam logic [3:0] V1        = 4'd3;
    localparam logic [3:0] V2        = 4'd4;
    localparam logic [3:0] V3        = 4'd5;
    localparam logic [3:0] V3D       = 4'd6;
    localparam logic [3:0] WAIT_SLOT = 4'd7;
    localparam logic [3:0] DRAIN     = 4'd8;
    localparam logic [3:0] DONE      = 4'd9;

    logic [3:0]   state, state_nxt;
    logic [20:0]  nf, face_ptr, face_ptr_nxt;
    logic [19:0]  fv2, fv3;
    logic [95:0]  vd1, vd2, vin;
    logic [287:0] mem [2];
    logic [1:0]   lmem;
    logic         wp, rp;
    logic [1:0]   cnt, cnt_nxt;
    logic         start, push, pop, last;

    assign vin   = {Color_v, vertice_z, vertice_y, vertice_x};
    assign start = enable && (state == IDLE || state == DONE);
    assign push  = state == V3D;
    assign pop   = tri_valid && tri_ready;
    assign last  = face_ptr == nf - 21'd1;
    assign cnt_nxt      = cnt + 2'(push) - 2'(pop);
    assign face_ptr_nxt = start ? '0 : push ? face_ptr + 21'd1 : face_ptr;

    assign tri_valid = cnt != 2'd0;
    assign tri_data  = mem[rp];
    assign tri_last  = tri_valid && lmem[rp];
    assign finish    = state == DONE;
    assign write_enable_sram_get_vertice_info   = 1'b1;
    assign write_wordmask_sram_get_vertice_info = 16'hFFFF;
    assign write_wordmask_sram_get_face         = 16'hFFFF;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? (num_of_faces == 21'd0 ? DONE : F_ADDR) : state;
            F_ADDR:     state_nxt = F_DATA;
            F_DATA:     state_nxt = V1;
            V1:         state_nxt = V2;
            V2:         state_nxt = V3;
            V3:         state_nxt = V3D;
            // the last face is the one being pushed, so issued reaches nf here
            V3D:        state_nxt = last ? DRAIN : cnt_nxt == 2'(FIFO_DEPTH) ? WAIT_SLOT : F_ADDR;
            WAIT_SLOT:  state_nxt = cnt_nxt < 2'(FIFO_DEPTH) ? F_ADDR : WAIT_SLOT;
            DRAIN:      state_nxt = (cnt == 2'd0 && pipe_idle) ? DONE : DRAIN;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state                         <= IDLE;
            nf                            <= '0;
            face_ptr                      <= '0;
            address_sram_get_face         <= '0;
            address_sram_get_vertice_info <= '0;
            fv2                           <= '0;
            fv3                           <= '0;
            vd1                           <= '0;
            vd2                           <= '0;
            mem[0]                        <= '0;
            mem[1]                        <= '0;
            lmem                          <= '0;
            wp                            <= 1'b0;
            rp                            <= 1'b0;
            cnt                           <= '0;
        end else begin
            state    <= state_nxt;
            face_ptr <= face_ptr_nxt;
            cnt      <= cnt_nxt;
            if (start)
                nf <= num_of_faces;
            if (state_nxt == F_ADDR)
                address_sram_get_face <= FACE_AW'(face_ptr_nxt);
            // vertex addresses are registered one state ahead so each Vn cycle presents its own index
            if (state == F_DATA) begin
                fv2                           <= face_v2;
                fv3                           <= face_v3;
                address_sram_get_vertice_info <= VERT_AW'(face_v1);
            end
            if (state == V1)
                address_sram_get_vertice_info <= VERT_AW'(fv2);
            if (state == V2) begin
                address_sram_get_vertice_info <= VERT_AW'(fv3);
                vd1                           <= vin;
            end
            if (state == V3)
                vd2 <= vin;
            if (push) begin
                mem[wp]  <= {vin, vd2, vd1};
                lmem[wp] <= last;
                wp       <= ~wp;
            end
            if (pop)
                rp <= ~rp;
        end
    end
endmodule

// File: tb/tb_tri_fetch_scheduler.sv
// tb_tri_fetch_scheduler: table, corner-case and randomized checks of tri_fetch_scheduler against a bundle-queue model
module tb_tri_fetch_scheduler;
    logic         clk = 0, srst_n = 0, enable = 0;
    logic [20:0]  num_of_faces = 0;
    logic [19:0]  address_sram_get_face, address_sram_get_vertice_info;
    logic [19:0]  face_v1 = 0, face_v2 = 0, face_v3 = 0;
    logic [23:0]  vertice_x = 0, vertice_y = 0, vertice_z = 0, Color_v = 0;
    logic         write_enable_sram_get_vertice_info;
    logic [15:0]  write_wordmask_sram_get_vertice_info, write_wordmask_sram_get_face;
    logic         tri_valid, tri_ready = 0, tri_last, pipe_idle = 0, finish;
    logic [287:0] tri_data;

    tri_fetch_scheduler dut (
        .clk(clk), .srst_n(srst_n), .enable(enable), .num_of_faces(num_of_faces),
        .address_sram_get_face(address_sram_get_face),
        .face_v1(face_v1), .face_v2(face_v2), .face_v3(face_v3),
        .address_sram_get_vertice_info(address_sram_get_vertice_info),
        .vertice_x(vertice_x), .vertice_y(vertice_y), .vertice_z(vertice_z), .Color_v(Color_v),
        .write_enable_sram_get_vertice_info(write_enable_sram_get_vertice_info),
        .write_wordmask_sram_get_vertice_info(write_wordmask_sram_get_vertice_info),
        .write_wordmask_sram_get_face(write_wordmask_sram_get_face),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data), .tri_last(tri_last),
        .pipe_idle(pipe_idle), .finish(finish)
    );

    always #5 clk = ~clk;

    logic [19:0] fm1 [64], fm2 [64], fm3 [64];

    function automatic logic [95:0] vert(input logic [19:0] i);
        logic [23:0] x;
        x = 24'({i, 20'd0});
        return {24'h0000FF + 24'(i), 24'h100000, -x, x};
    endfunction

    always @(posedge clk) begin
        face_v1 <= fm1[address_sram_get_face[5:0]];
        face_v2 <= fm2[address_sram_get_face[5:0]];
        face_v3 <= fm3[address_sram_get_face[5:0]];
        {Color_v, vertice_z, vertice_y, vertice_x} <= vert(address_sram_get_vertice_info);
    end

    typedef struct {logic [287:0] d; logic l;} bnd_t;
    typedef struct {logic [19:0] v1, v2, v3; int vcyc; int fcyc;} row_t;
    bnd_t exp_q[$];
    int passed = 0, total = 0;
    int cyc, fin_cyc, rdy_mode, rdy_from, idle_from, en_at = -1;
    logic [20:0] en_nf;
    int valid_cyc[$], xfer_cyc[$];
    logic [19:0] fa_log [256], va_log [256];

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    endtask

    task automatic chk_d(input string n, input logic [287:0] a, input logic [287:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    endtask

    task automatic load_exp(input int nf);
        bnd_t b;
        exp_q.delete();
        for (int f = 0; f < nf; f++) begin
            b.d = {vert(fm3[f]), vert(fm2[f]), vert(fm1[f])};
            b.l = (f == nf - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic rand_faces(input int n);
        for (int f = 0; f < n; f++) begin
            fm1[f] = 20'($urandom);
            fm2[f] = 20'($urandom);
            fm3[f] = 20'($urandom);
        end
    endtask

    task automatic tick();
        logic hold;
        logic [287:0] held;
        bnd_t b;
        tri_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : (cyc >= rdy_from);
        pipe_idle = idle_from < 0 ? 1'($urandom_range(0, 1)) : (cyc >= idle_from);
        if (cyc == en_at) begin
            enable = 1;
            num_of_faces = en_nf;
        end
        if (tri_valid) valid_cyc.push_back(cyc);
        if (tri_valid && tri_ready) begin
            xfer_cyc.push_back(cyc);
            chk("bundle_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk_d("tri_data", tri_data, b.d);
                chk("tri_last", int'(tri_last), int'(b.l));
            end
        end
        hold = tri_valid && !tri_ready;
        held = tri_data;
        @(posedge clk);
        #1;
        cyc++;
        enable = 0;
        if (hold) begin
            chk("head_valid_held", int'(tri_valid), 1);
            chk_d("head_data_held", tri_data, held);
        end
        if (cyc < 256) begin
            fa_log[cyc] = address_sram_get_face;
            va_log[cyc] = address_sram_get_vertice_info;
        end
        if (finish && fin_cyc < 0) fin_cyc = cyc;
    endtask

    task automatic start_frame(input int nf);
        cyc = 0;
        fin_cyc = -1;
        valid_cyc.delete();
        xfer_cyc.delete();
        load_exp(nf);
        num_of_faces = 21'(nf);
        enable = 1;
        fa_log[0] = address_sram_get_face;
        va_log[0] = address_sram_get_vertice_info;
    endtask

    task automatic run_to_finish(input int maxc);
        while (fin_cyc < 0 && cyc < maxc) tick();
        chk("finish_seen", int'(fin_cyc >= 0), 1);
        chk("all_consumed", exp_q.size(), 0);
    endtask

    row_t rows[4];

    initial begin
        rows[0] = '{20'd5, 20'd9, 20'd2, 7, 13};
        rows[1] = '{20'd0, 20'd0, 20'd0, 7, 13};
        rows[2] = '{20'd7, 20'd7, 20'd3, 7, 13};
        rows[3] = '{20'hFFFFF, 20'd1, 20'h80000, 7, 13};
        for (int f = 0; f < 64; f++) begin
            fm1[f] = 0;
            fm2[f] = 0;
            fm3[f] = 0;
        end
        rdy_mode = 0;
        idle_from = 0;
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_face_addr", int'(address_sram_get_face), 0);
        chk("rst_vert_addr", int'(address_sram_get_vertice_info), 0);
        chk("rst_tri_valid", int'(tri_valid), 0);
        chk("rst_tri_last", int'(tri_last), 0);
        chk("rst_finish", int'(finish), 0);
        chk_d("rst_tri_data", tri_data, '0);
        chk("rst_we", int'(write_enable_sram_get_vertice_info), 1);
        chk("rst_wm_vert", int'(write_wordmask_sram_get_vertice_info), 16'hFFFF);
        chk("rst_wm_face", int'(write_wordmask_sram_get_face), 16'hFFFF);
        srst_n = 1;

        // zero faces straight from IDLE
        start_frame(0);
        run_to_finish(10);
        chk("nf0_finish_cycle", fin_cyc, 1);
        chk("nf0_face_addr", int'(fa_log[1]), 0);
        chk("nf0_vert_addr", int'(va_log[1]), 0);
        chk("nf0_no_valid", valid_cyc.size(), 0);

        // single-face vectors: address schedule, first valid cycle, finish after pipe_idle
        foreach (rows[r]) begin
            fm1[0] = rows[r].v1;
            fm2[0] = rows[r].v2;
            fm3[0] = rows[r].v3;
            rdy_mode = 0;
            idle_from = 12;
            start_frame(1);
            run_to_finish(60);
            chk("row_face_addr_c1", int'(fa_log[1]), 0);
            chk("row_vaddr_c3", int'(va_log[3]), int'(rows[r].v1));
            chk("row_vaddr_c4", int'(va_log[4]), int'(rows[r].v2));
            chk("row_vaddr_c5", int'(va_log[5]), int'(rows[r].v3));
            chk("row_valid_count", valid_cyc.size(), 1);
            if (valid_cyc.size() > 0) chk("row_first_valid", valid_cyc[0], rows[r].vcyc);
            chk("row_finish_cycle", fin_cyc, rows[r].fcyc);
        end

        // four faces, no backpressure: 6-cycle cadence
        rand_faces(4);
        rdy_mode = 0;
        idle_from = 0;
        start_frame(4);
        run_to_finish(100);
        chk("nf4_valid_count", valid_cyc.size(), 4);
        foreach (valid_cyc[i]) chk("nf4_valid_cycle", valid_cyc[i], 7 + 6 * i);
        chk("nf4_finish_cycle", fin_cyc, 27);

        // four faces, consumer stalled until cycle 30
        rand_faces(4);
        rdy_mode = 2;
        rdy_from = 30;
        start_frame(4);
        run_to_finish(150);
        chk("stall_face_addr_c29", int'(fa_log[29]), 1);
        chk("stall_vert_addr_c29", int'(va_log[29]), int'(fm3[1]));
        chk("stall_face_addr_c31", int'(fa_log[31]), 2);
        chk("stall_xfer_count", xfer_cyc.size(), 4);
        if (xfer_cyc.size() > 0) chk("stall_first_xfer", xfer_cyc[0], 30);

        // enable pulse mid-frame must be ignored
        rand_faces(3);
        rdy_mode = 0;
        start_frame(3);
        en_at = 10;
        en_nf = 21'd5;
        run_to_finish(150);
        en_at = -1;
        chk("busy_en_xfer_count", xfer_cyc.size(), 3);

        // reset during V2 of face 2, then a fresh two-face frame
        rand_faces(4);
        fm2[2] = 20'h12345;
        start_frame(4);
        while (cyc < 16) tick();
        chk("pre_rst_vert_addr", int'(address_sram_get_vertice_info), int'(fm2[2]));
        srst_n = 0;
        #1;
        chk("mid_rst_face_addr", int'(address_sram_get_face), 0);
        chk("mid_rst_vert_addr", int'(address_sram_get_vertice_info), 0);
        chk("mid_rst_tri_valid", int'(tri_valid), 0);
        chk("mid_rst_tri_last", int'(tri_last), 0);
        chk("mid_rst_finish", int'(finish), 0);
        chk_d("mid_rst_tri_data", tri_data, '0);
        repeat (2) @(posedge clk);
        #1;
        srst_n = 1;
        start_frame(2);
        run_to_finish(100);
        chk("post_rst_xfer_count", xfer_cyc.size(), 2);
        if (valid_cyc.size() > 0) chk("post_rst_first_valid", valid_cyc[0], 7);

        // randomized frames with random backpressure and pipe_idle
        for (int k = 0; k < 8; k++) begin
            int nf;
            nf = $urandom_range(1, 6);
            rand_faces(nf);
            rdy_mode = 1;
            idle_from = -1;
            start_frame(nf);
            run_to_finish(400);
            chk("rand_xfer_count", xfer_cyc.size(), nf);
            chk("rand_idle_after_finish", int'(tri_valid), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
